// File: rtl/axi_wresp_chs.sv
// axi_wresp_chs -- write response channel stage of the AXI MMU wrapper.
//
// Records each write's translation outcome in issue order. Translated writes
// get the master-side B beat forwarded to the slave port; dropped writes get a
// locally generated error response once the write data stage has drained the
// burst. Exactly one in-order B response is produced per accepted write address.
//
// Ports:
//   clk          clock
//   reset_       asynchronous active-low reset
//   done         pulse: translation ok, write issued to master (push tag 0)
//   drop         pulse: translation failed (push tag 1)
//   drop_done    pulse: a dropped burst has been fully drained (drop credit)
//   in_bresp     master B response
//   in_buser     master B user field
//   in_mbvalid   master B valid
//   out_mbready  master B ready (combinational, high only in FWD)
//   out_bresp    slave B response (registered)
//   out_buser    slave B user field (registered)
//   out_sbvalid  slave B valid (registered)
//   in_sbready   slave B ready
//   out_pending  order FIFO occupancy
//   out_err      sticky protocol error, cleared only by reset

module axi_wresp_chs #(
    parameter int unsigned ORDER_DEPTH = 16,
    parameter int unsigned USER_WIDTH  = 2,
    parameter logic [1:0]  ERR_RESP    = 2'b11
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          done,
    input  logic                          drop,
    input  logic                          drop_done,
    input  logic [1:0]                    in_bresp,
    input  logic [USER_WIDTH-1:0]         in_buser,
    input  logic                          in_mbvalid,
    output logic                          out_mbready,
    output logic [1:0]                    out_bresp,
    output logic [USER_WIDTH-1:0]         out_buser,
    output logic                          out_sbvalid,
    input  logic                          in_sbready,
    output logic [$clog2(ORDER_DEPTH):0]  out_pending,
    output logic                          out_err
);

    localparam int unsigned PtrW = $clog2(ORDER_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [CntW-1:0] CntOne = 1;
    localparam logic [CntW-1:0] CntFull = CntW'(ORDER_DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFwd     = 2'd1,
        StErrWait = 2'd2,
        StSend    = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Order FIFO: one tag bit per outstanding write (1 = locally generated error).
    logic [ORDER_DEPTH-1:0] tag_q;
    logic [PtrW-1:0]        wptr_q, rptr_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        credit_q, credit_d;
    logic                   err_q;

    logic push_req, push, pop, fifo_full, fifo_empty, head_tag;
    logic consume, credit_sat, err_set;
    logic load_fwd;

    //--------------------------------------------------------------------------
    // FIFO and credit bookkeeping
    //--------------------------------------------------------------------------
    always_comb begin
        push_req   = done | drop;
        fifo_full  = (cnt_q == CntFull);
        fifo_empty = (cnt_q == '0);
        push       = push_req & ~fifo_full;
        pop        = out_sbvalid & in_sbready;
        head_tag   = tag_q[rptr_q];

        // An error entry is consumed once a drained-burst credit exists, or
        // arrives in this very cycle.
        consume    = (state_q == StErrWait) & ((credit_q != '0) | drop_done);
        credit_sat = drop_done & ~consume & (credit_q == '1);
        err_set    = (done & drop) | (push_req & fifo_full) | credit_sat;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase

        credit_d = credit_q;
        if (drop_done && !consume && !credit_sat) begin
            credit_d = credit_q + CntOne;
        end else if (!drop_done && consume) begin
            credit_d = credit_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            tag_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                // Simultaneous done+drop records the failure only.
                tag_q[wptr_q] <= drop;
                wptr_q        <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Response FSM: state register / next state / outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = head_tag ? StErrWait : StFwd;
                end
            end
            StFwd: begin
                if (in_mbvalid) begin
                    state_d = StSend;
                end
            end
            StErrWait: begin
                if (consume) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (in_sbready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_mbready = (state_q == StFwd);
        load_fwd    = out_mbready & in_mbvalid;
    end

    // Slave B payload: loaded on entry to SEND, held until the handshake.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_sbvalid <= 1'b0;
            out_bresp   <= 2'b00;
            out_buser   <= '0;
        end else if (load_fwd) begin
            out_sbvalid <= 1'b1;
            out_bresp   <= in_bresp;
            out_buser   <= in_buser;
        end else if (consume) begin
            out_sbvalid <= 1'b1;
            out_bresp   <= ERR_RESP;
            out_buser   <= '0;
        end else if (pop) begin
            out_sbvalid <= 1'b0;
        end
    end

    assign out_pending = cnt_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_axi_wresp_chs.sv
// Bench for axi_wresp_chs: directed scenarios followed by random traffic, all
// scored against a transaction-level model (queue of outcome tags, queue of
// master beats in presentation order, sticky error flag).

module tb_axi_wresp_chs;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       done = 1'b0, drop = 1'b0, drop_done = 1'b0;
    logic [1:0] in_bresp = 2'b00;
    logic [1:0] in_buser = 2'b00;
    logic       in_mbvalid = 1'b0;
    logic       out_mbready;
    logic [1:0] out_bresp;
    logic [1:0] out_buser;
    logic       out_sbvalid;
    logic       in_sbready = 1'b0;
    logic [4:0] out_pending;
    logic       out_err;

    axi_wresp_chs #(
        .ORDER_DEPTH(16),
        .USER_WIDTH (2),
        .ERR_RESP   (2'b11)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .done       (done),
        .drop       (drop),
        .drop_done  (drop_done),
        .in_bresp   (in_bresp),
        .in_buser   (in_buser),
        .in_mbvalid (in_mbvalid),
        .out_mbready(out_mbready),
        .out_bresp  (out_bresp),
        .out_buser  (out_buser),
        .out_sbvalid(out_sbvalid),
        .in_sbready (in_sbready),
        .out_pending(out_pending),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit         tq[$];        // outcome tags in issue order (1 = error)
    logic [3:0] mq[$];        // master beats still to be presented {bresp,buser}
    logic [3:0] fwd_exp[$];   // every master beat, in order, awaiting forwarding
    logic [3:0] hs_log[$];    // slave handshakes seen
    bit         err_exp = 0;
    bit         mb_en = 1;
    int         n_drops = 0;
    int         n_dd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input logic [3:0] b);
        mq.push_back(b);
        fwd_exp.push_back(b);
    endtask

    // One clock: drive inputs, capture pre-edge handshake view, clock, then
    // score the edge against the model. Returns 1 time unit after the edge.
    task automatic step(input logic d, input logic dr, input logic dd, input logic sbr);
        logic       pre_sbv, pre_mbr, pre_mbv;
        logic [3:0] pre_pay, exp, dummy;
        int         sz0;
        bit         t;
        done       = d;
        drop       = dr;
        drop_done  = dd;
        in_sbready = sbr;
        in_mbvalid = mb_en && (mq.size() > 0);
        if (mq.size() > 0) {in_bresp, in_buser} = mq[0];
        else {in_bresp, in_buser} = 4'h0;
        #1;
        pre_sbv = out_sbvalid;
        pre_mbr = out_mbready;
        pre_mbv = in_mbvalid;
        pre_pay = {out_bresp, out_buser};
        sz0     = tq.size();
        @(posedge clk);
        #1;
        if (pre_mbv && pre_mbr) begin
            chk("accept_at_fwd_head", 32'((sz0 > 0) && (tq[0] == 1'b0)), 1);
            dummy = mq.pop_front();
        end
        if (pre_sbv && sbr) begin
            chk("entry_for_resp", 32'(tq.size() > 0), 1);
            if (tq.size() > 0) begin
                t = tq.pop_front();
                if (t) exp = {2'b11, 2'b00};
                else if (fwd_exp.size() > 0) exp = fwd_exp.pop_front();
                else exp = 4'hx;
                chk("b_payload", 32'(pre_pay), 32'(exp));
            end
            hs_log.push_back(pre_pay);
        end else if (pre_sbv) begin
            chk("hold_valid", 32'(out_sbvalid), 1);
            chk("hold_payload", 32'({out_bresp, out_buser}), 32'(pre_pay));
        end
        if (d || dr) begin
            if (sz0 < 16) begin
                tq.push_back(dr);
                if (dr) n_drops++;
            end else begin
                err_exp = 1;
            end
            if (d && dr) err_exp = 1;
        end
        if (dd) n_dd++;
        chk("pending", 32'(out_pending), 32'(tq.size()));
        chk("err", 32'(out_err), 32'(err_exp));
    endtask

    task automatic model_reset();
        tq.delete();
        mq.delete();
        fwd_exp.delete();
        hs_log.delete();
        err_exp = 0;
        n_drops = 0;
        n_dd    = 0;
    endtask

    // Run until the model has no outstanding entries, feeding credits and beats.
    task automatic drain(input string tag);
        int guard = 0;
        logic give_dd;
        mb_en = 1;
        while (tq.size() > 0 && guard < 400) begin
            if (mq.size() == 0) add_beat(4'($urandom_range(0, 15)));
            give_dd = (n_dd < n_drops);
            step(0, 0, give_dd, 1);
            guard++;
        end
        chk({tag, "_drained"}, 32'(out_pending), 0);
    endtask

    initial begin
        // ---- Reset state ----
        #12;
        chk("rst_sbvalid", 32'(out_sbvalid), 0);
        chk("rst_mbready", 32'(out_mbready), 0);
        chk("rst_pending", 32'(out_pending), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_bresp", 32'(out_bresp), 0);
        chk("rst_buser", 32'(out_buser), 0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // ---- 1: single forward ----
        add_beat({2'b00, 2'b01});
        step(1, 0, 0, 1);
        chk("t1_mbready_c0", 32'(out_mbready), 0);
        step(0, 0, 0, 1);
        chk("t1_mbready_c1", 32'(out_mbready), 1);
        step(0, 0, 0, 1);
        chk("t1_sbvalid_c2", 32'(out_sbvalid), 1);
        chk("t1_payload_c2", 32'({out_bresp, out_buser}), 32'(4'b0001));
        step(0, 0, 0, 1);
        chk("t1_sbvalid_c3", 32'(out_sbvalid), 0);
        chk("t1_pending_c3", 32'(out_pending), 0);

        // ---- 2: single drop, master beat pending throughout ----
        add_beat({2'b00, 2'b10});   // OKAY, later forwarded in test 3
        step(0, 1, 0, 1);
        for (int i = 1; i < 5; i++) begin
            step(0, 0, 0, 1);
            chk("t2_mbready_low", 32'(out_mbready), 0);
            chk("t2_sbvalid_low", 32'(out_sbvalid), 0);
        end
        step(0, 0, 1, 1);
        chk("t2_sbvalid", 32'(out_sbvalid), 1);
        chk("t2_bresp", 32'(out_bresp), 32'(2'b11));
        chk("t2_mbready", 32'(out_mbready), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // ---- 3: ordering drop, done, done ----
        add_beat({2'b10, 2'b11});   // SLVERR
        hs_log.delete();
        step(0, 1, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 3; i < 10; i++) step(0, 0, 0, 1);
        chk("t3_no_early_accept", 32'(mq.size()), 2);
        chk("t3_no_early_resp", 32'(hs_log.size()), 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        chk("t3_n_resp", 32'(hs_log.size()), 3);
        if (hs_log.size() == 3) begin
            chk("t3_first_decerr", 32'(hs_log[0][3:2]), 32'(2'b11));
            chk("t3_second_okay", 32'(hs_log[1][3:2]), 32'(2'b00));
            chk("t3_third_slverr", 32'(hs_log[2][3:2]), 32'(2'b10));
        end

        // ---- 4: early credit and backpressure ----
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t4_sbvalid", 32'(out_sbvalid), 1);
        chk("t4_bresp", 32'(out_bresp), 32'(2'b11));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("t4_stall_pending", 32'(out_pending), 1);
        end
        step(0, 0, 0, 1);
        chk("t4_popped", 32'(out_pending), 0);
        chk("t4_sbvalid_low", 32'(out_sbvalid), 0);

        // ---- 5: fill to 16, then overflow ----
        mb_en = 0;
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1);
        chk("t5_full", 32'(out_pending), 16);
        chk("t5_no_err_yet", 32'(out_err), 0);
        step(1, 0, 0, 1);
        chk("t5_full_kept", 32'(out_pending), 16);
        chk("t5_overflow_err", 32'(out_err), 1);
        drain("t5");

        // ---- 6: reset while a response is on the slave port ----
        add_beat({2'b01, 2'b10});
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_sbvalid_before", 32'(out_sbvalid), 1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("t6_rst_sbvalid", 32'(out_sbvalid), 0);
        chk("t6_rst_pending", 32'(out_pending), 0);
        chk("t6_rst_err", 32'(out_err), 0);
        chk("t6_rst_mbready", 32'(out_mbready), 0);
        model_reset();
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        add_beat({2'b00, 2'b01});
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("t6_mbready_c1", 32'(out_mbready), 1);
        step(0, 0, 0, 1);
        chk("t6_sbvalid_c2", 32'(out_sbvalid), 1);
        chk("t6_payload_c2", 32'({out_bresp, out_buser}), 32'(4'b0001));
        step(0, 0, 0, 1);

        // ---- 5b: simultaneous done+drop ----
        step(1, 1, 0, 1);
        chk("t5b_one_entry", 32'(out_pending), 1);
        chk("t5b_err", 32'(out_err), 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("t5b_err_resp", 32'(out_bresp), 32'(2'b11));
        drain("t5b");

        // ---- Random traffic ----
        for (int c = 0; c < 1500; c++) begin
            int   r;
            logic d, dr, dd;
            r  = $urandom_range(0, 9);
            d  = (r < 2) && (tq.size() < 16);
            dr = (r == 2) && (tq.size() < 16);
            dd = (n_dd < n_drops) && ($urandom_range(0, 3) == 0);
            mb_en = ($urandom_range(0, 3) != 0);
            if (mq.size() < 4 && $urandom_range(0, 2) == 0) add_beat(4'($urandom_range(0, 15)));
            step(d, dr, dd, $urandom_range(0, 2) != 0);
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wresp_chs.md
# axi_wresp_chs

Write response channel stage of the AXI MMU wrapper, downstream of the write data channel receiver. It records each write's translation outcome in issue order. For translated writes it forwards the master-side B response to the slave port. For dropped writes it waits until the write data stage reports the burst drained (`drop_done`), then returns a locally generated error response. The result is one in-order B response per accepted write address.

## Interface

**Parameters**
- `ORDER_DEPTH`, 16: entries in the outcome-order FIFO; power of two.
- `USER_WIDTH`, 2: width of the B-channel user field.
- `ERR_RESP`, 2'b11: BRESP value returned for dropped writes (DECERR).

**Ports**
- `clk`, in, 1: single clock.
- `reset_`, in, 1: asynchronous, active-low reset.
- `done`, in, 1: one-cycle pulse; translation succeeded and the write was issued to the master.
- `drop`, in, 1: one-cycle pulse; translation failed.
- `drop_done`, in, 1: one-cycle pulse from the write data stage; a dropped burst has been fully drained.
- `in_bresp`, in, 2: master B response.
- `in_buser`, in, USER_WIDTH: master B user field.
- `in_mbvalid`, in, 1: master B valid.
- `out_mbready`, out, 1: master B ready; combinational, equal to (state==FWD).
- `out_bresp`, out, 2: slave B response; registered.
- `out_buser`, out, USER_WIDTH: slave B user field; registered.
- `out_sbvalid`, out, 1: slave B valid; registered.
- `in_sbready`, in, 1: slave B ready.
- `out_pending`, out, clog2(ORDER_DEPTH)+1: current order-FIFO occupancy.
- `out_err`, out, 1: sticky protocol error; cleared only by reset.

## Operation

**Order FIFO (1-bit tag)**
- `done` pushes tag 0 (forward); `drop` pushes tag 1 (error).
- `done` and `drop` asserted in the same cycle: push tag 1 only and set `out_err`.
- Push while full: the push is discarded and `out_err` is set.
- Pop happens only on the slave handshake (`out_sbvalid & in_sbready`).
- Push and pop in the same cycle are both performed; occupancy is unchanged.

**Drop credit counter**
- Width is clog2(ORDER_DEPTH)+1.
- `drop_done` increments it; consuming an error entry decrements it.
- Increment and decrement in the same cycle leave it unchanged.
- Increment at maximum saturates and sets `out_err`.

**State machine** (IDLE=0, FWD=1, ERR_WAIT=2, SEND=3)
- **IDLE:** if the FIFO is non-empty, go to FWD when the head tag is 0, or to ERR_WAIT when the head tag is 1. Otherwise stay in IDLE.
- **FWD:** `out_mbready`=1. When `in_mbvalid` is high, register `in_bresp`/`in_buser` into the outputs, set `out_sbvalid`=1 and go to SEND.
- **ERR_WAIT:** the cycle in which credit>0 or `drop_done`=1 is the consume cycle. In that cycle, load `out_bresp`=ERR_RESP and `out_buser`=0, set `out_sbvalid`=1, decrement credit and go to SEND.
- **SEND:** hold all outputs stable until `in_sbready`. On the handshake, clear `out_sbvalid`, pop the FIFO and go to IDLE.
- A master B beat is never accepted outside FWD. A master B arriving with no tag-0 entry at the head stalls (ready stays low).

**Reset** (asynchronous, any time, including mid-response)
- State goes to IDLE; FIFO pointers, occupancy and credit clear to 0.
- `out_sbvalid`=0, `out_bresp`=0, `out_buser`=0, `out_err`=0.
- `out_mbready`=0, since the state is IDLE.

## Timing
- A push at edge N is visible to IDLE at cycle N+1; the state reaches FWD/ERR_WAIT at edge N+1.
- Forward path, minimum latency: `done` at cycle 0 → `out_mbready` high in cycle 1 → `out_sbvalid` high in cycle 2 if `in_mbvalid` was high in cycle 1.
- Error path: `drop` at 0 plus `drop_done` at k≥1 → `out_sbvalid` high at max(2, k+1).
- There is one IDLE bubble cycle between consecutive responses. Maximum throughput is one response per 3 cycles with `in_sbready` held high.
- `out_sbvalid` never deasserts without a handshake; payload never changes while valid is high.
- `out_pending` is updated on the clock edge following the push/pop.

## Test plan
1. **Single forward:** `done` at cycle 0; `in_mbvalid` with bresp=0, buser=2'b01 held from cycle 0; `in_sbready`=1. Expected: `out_mbready`=1 at cycle 1; `out_sbvalid`=1, bresp=0, buser=1 at cycle 2; `out_pending` returns to 0 after cycle 3.
2. **Single drop:** `drop` at 0, `drop_done` at 5, `in_mbvalid`=1 throughout. Expected: `out_mbready` stays 0; `out_sbvalid`=1 with bresp=2'b11 at cycle 6.
3. **Ordering:** `drop`, `done`, `done` on cycles 0, 1, 2; master B (OKAY, SLVERR) available from cycle 0; `drop_done` at 10. Expected: responses emitted DECERR, OKAY, SLVERR in that order; no master beat accepted before cycle 11.
4. **Backpressure and early credit:** `drop_done` arrives before the state reaches ERR_WAIT; `in_sbready` is held low for 4 cycles. Expected: the credit is used on entry to ERR_WAIT; `out_sbvalid` and `out_bresp` stay stable for 4 cycles; pop occurs only on the handshake.
5. **Full and errors:** 16 `done` pulses with no master B, then a 17th `done`. Expected: `out_pending`=16 and `out_err`=1. Also: simultaneous `done`+`drop` pushes exactly one tag-1 entry and sets `out_err`.
6. **Reset mid-SEND:** assert `reset_`=0 while `out_sbvalid`=1. Expected: `out_sbvalid`, `out_pending` and `out_err` all clear asynchronously; the next `done` behaves as in test 1.
